// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE      = 16;
    localparam int MID_SAMPLE      = 7;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Reset to 1 so a freshly reset receiver sees an idle line, not a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1 frame recovery, LSB first.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            baudtick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    output logic            frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [3:0]      s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;

        case (state_q)
            // Start edge is taken on any clock so the mid-bit point stays tick-accurate.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = 4'd0;
                end
            end
            START: begin
                if (baudtick) begin
                    if (s_cnt_q == 4'(MID_SAMPLE)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = 4'd0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (baudtick) begin
                    if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        s_cnt_d = 4'd0;
                        if (n_cnt_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (baudtick) begin
                    if (s_cnt_q == 4'(SB_TICK - 1)) begin
                        rx_data_d   = shreg_q;
                        frame_err_d = ~rx_s;
                        rx_valid_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_cnt_q     <= 4'd0;
            n_cnt_q     <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal-timing serial frames against a byte-level scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TICK_DIV = 28;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       baudtick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    logic [4:0] div = 5'd0;
    logic       tick_en = 1'b1;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       pre_glitch;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    rec_t got[$];
    logic prev_valid = 1'b0;
    int   wide_pulses = 0;

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .baudtick  (baudtick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick_en) div <= (div == 5'(TICK_DIV - 1)) ? 5'd0 : div + 5'd1;
    end
    assign baudtick = tick_en && (div == 5'(TICK_DIV - 1));

    always @(negedge clk) begin
        if (rx_valid) begin
            if (prev_valid) wide_pulses <= wide_pulses + 1;
            else got.push_back('{rx_data, frame_err, cyc});
        end
        prev_valid <= rx_valid;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_phase();
        do @(negedge clk); while (div != 5'd10);
    endtask

    // A bad stop bit is low only long enough to cover its sampling point.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input logic align, input int stall_bit,
                              output int start_cyc);
        if (align) align_phase();
        start_cyc = cyc;
        rx = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == stall_bit) begin
                hold(BIT_CLKS / 2);
                tick_en = 1'b0;
                hold(1000);
                tick_en = 1'b1;
                hold(BIT_CLKS / 2);
            end else begin
                hold(BIT_CLKS);
            end
        end
        if (stop_ok) begin
            rx = 1'b1;
            hold(BIT_CLKS);
        end else begin
            rx = 1'b0;
            hold(300);
            rx = 1'b1;
            hold(BIT_CLKS - 300);
        end
    endtask

    task automatic next_rec(input string name, output rec_t r, output logic ok);
        int w = 0;
        while (got.size() == 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        ok = (got.size() != 0);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no rx_valid within bound, expected one", name);
            r = '{8'h00, 1'b0, 0};
        end else begin
            r = got.pop_front();
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d, input logic fe,
                               output rec_t r);
        logic ok;
        next_rec(name, r, ok);
        if (ok) begin
            chk({name, "_data"}, int'(r.data), int'(d));
            chk({name, "_ferr"}, int'(r.ferr), int'(fe));
        end
    endtask

    // Reference: a frame yields its byte, flagged when the stop bit was low.
    function automatic rec_t model(input logic [7:0] b, input logic stop_ok);
        return '{b, ~stop_ok, 0};
    endfunction

    initial begin
        vec_t vecs[4];
        rec_t r, r2, m;
        int   sc, lat0, lat1;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'hA3, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

        hold(3);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        hold(BIT_CLKS);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].pre_glitch) begin
                rx = 1'b0;
                hold(3 * TICK_DIV);
                rx = 1'b1;
                hold(600);
                chk("glitch_state_idle", int'(dut.state_q), int'(IDLE));
                chk("glitch_no_valid", got.size(), 0);
            end
            send_frame(vecs[i].data, vecs[i].stop_ok, 1'b1, -1, sc);
            expect_byte($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr, r);
            hold(BIT_CLKS);
        end

        send_frame(8'h00, 1'b1, 1'b1, -1, sc);
        send_frame(8'hFF, 1'b1, 1'b0, -1, sc);
        expect_byte("b2b_first", 8'h00, 1'b0, r);
        expect_byte("b2b_second", 8'hFF, 1'b0, r2);
        chk_range("b2b_spacing", r2.cyc - r.cyc, 10 * BIT_CLKS - TICK_DIV, 10 * BIT_CLKS + TICK_DIV);
        hold(BIT_CLKS);

        send_frame(8'h77, 1'b0, 1'b1, -1, sc);
        expect_byte("pre_reset", 8'h77, 1'b1, r);
        hold(BIT_CLKS);

        align_phase();
        fork
            send_frame(8'hF5, 1'b1, 1'b0, -1, sc);
            begin
                hold(5 * BIT_CLKS + 200);
                reset = 1'b1;
                @(negedge clk);
                chk("midreset_rx_data", int'(rx_data), 0);
                chk("midreset_rx_valid", int'(rx_valid), 0);
                chk("midreset_frame_err", int'(frame_err), 0);
                reset = 1'b0;
            end
        join
        hold(BIT_CLKS);
        chk("midreset_no_valid", got.size(), 0);

        send_frame(8'hC6, 1'b1, 1'b1, -1, sc);
        expect_byte("after_reset", 8'hC6, 1'b0, r);
        lat0 = r.cyc - sc;
        chk_range("latency", lat0, 9 * BIT_CLKS + BIT_CLKS / 2 + 2 - TICK_DIV,
                  9 * BIT_CLKS + BIT_CLKS / 2 + 2 + TICK_DIV);
        hold(BIT_CLKS);

        send_frame(8'h3A, 1'b1, 1'b1, 3, sc);
        expect_byte("stall", 8'h3A, 1'b0, r);
        lat1 = r.cyc - sc;
        chk("stall_delay", lat1 - lat0, 1000);
        hold(BIT_CLKS);

        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            m  = model(b, ok);
            send_frame(b, ok, 1'($urandom_range(0, 1)), -1, sc);
            expect_byte($sformatf("rand%0d", i), m.data, m.ferr, r);
            hold($urandom_range(0, 600));
        end

        hold(BIT_CLKS);
        chk("leftover_valids", got.size(), 0);
        chk("valid_pulse_width", wide_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive engine; the consumer of the 16x-oversampling `baudtick` produced by the baud generator.
- Samples the asynchronous serial line and recovers 8N1-style frames, LSB first.
- Presents each received byte as a one-cycle valid pulse with a frame-error flag.
- Sits between the external RX pin and the UART-to-AXI command decoder.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, oversample ticks spent in the stop bit (16 = one stop bit).
- OVERSAMPLE, 16, baudtick pulses per bit period. Fixed; must match the baud generator.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baudtick  input  1  one-clk pulse, 16 per bit period.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DBIT  last received byte. Held until the next valid.
- rx_valid  output  1  one-clk pulse: rx_data/frame_err are updated this cycle.
- frame_err  output  1  stop bit sampled low for the byte reported with rx_valid.

Behaviour:
- Reset:
  - Sampled on posedge clk while reset=1.
  - Forces state=IDLE; s_cnt=0, n_cnt=0, shift register=0.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0. Synchronizer flops are set to 1 (line idle).
  - Reset mid-frame abandons the frame silently; no rx_valid is produced for it.
- Input sync: rx passes through 2 flops (rx_s). All decisions below use rx_s only.
- Counters:
  - s_cnt is 4 bits, counts baudtick pulses. n_cnt is clog2(DBIT) bits, counts data bits.
  - Counters advance only on clk edges where baudtick=1.
- State IDLE:
  - rx_s==0 moves to START with s_cnt=0. This happens on any clk edge; it does not wait for a tick.
- State START:
  - On a tick with s_cnt==7 (mid start bit):
    - rx_s==0: move to DATA, s_cnt=0, n_cnt=0.
    - rx_s==1: treat as a glitch and return to IDLE. No output.
  - Otherwise, on a tick: s_cnt++.
- State DATA:
  - On a tick with s_cnt==15:
    - shreg = {rx_s, shreg[DBIT-1:1]} (LSB-first), s_cnt=0.
    - If n_cnt==DBIT-1, move to STOP; otherwise n_cnt++.
  - Otherwise, on a tick: s_cnt++.
- State STOP:
  - On a tick with s_cnt==SB_TICK-1:
    - rx_data<=shreg, frame_err<=~rx_s, rx_valid<=1 (exactly one clk), then IDLE.
  - Otherwise, on a tick: s_cnt++.
- Framing error:
  - The byte is still delivered; frame_err=1 accompanies that rx_valid.
  - frame_err holds its value until the next rx_valid.
- Break condition (line stuck low after the frame):
  - Re-enters START immediately from IDLE.
  - Each additional 0x00 frame is reported with frame_err=1.
- Latency: rx_valid rises on the clk edge after the stop-bit sampling tick. Total ≈ 9.5 bit times from the start edge, plus 2 sync clks.
- Back-to-back frames: the next start edge may arrive in the cycle IDLE is entered. No gap is required, and no byte is dropped.
- baudtick held low: the FSM freezes in its current state; no timeout.
- No flow control: the consumer must accept rx_valid in the same cycle. Overrun is not detected.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP} (2-bit encoding);
  - constants OVERSAMPLE=16 and MID_SAMPLE=7;
  - default DBIT=8 and SB_TICK=16.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset value 1, reusable for other async inputs.
- The baud generator is instantiated by the parent, not inside uart_rx.

Test Plan (CLK=50MHz, BAUDRATE=115200; baudgen period 28 clks, bit time 448 clks; bench drives rx with ideal timing and instantiates baudgen):
- Send 0x55, stop=1 -> one rx_valid pulse, rx_data=0x55, frame_err=0, rx_valid width exactly 1 clk.
- Send 0xA3 with stop bit driven 0 -> rx_valid with rx_data=0xA3, frame_err=1. Then send 0x3C with a valid stop bit -> frame_err=0.
- rx low pulse of 3 ticks (84 clks) while idle -> no rx_valid, FSM back in IDLE. A following 0x81 is received correctly.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses 10 bit times (4480 clks ±28) apart, data 0x00 then 0xFF, frame_err=0 both.
- Assert reset for 1 clk during bit 4 of a frame -> all outputs 0 next cycle and no rx_valid for that frame. A frame 0xC6 after the line has been idle ≥1 bit is received as 0xC6.
- Hold baudtick=0 for 1000 clks mid-frame, then resume -> FSM holds state and counters. The frame completes correctly with delay equal to the stall.
